// File: rtl/multiport_memory_controller_if.sv
//==============================================================================
// Module      : multiport_memory_controller_if
// Description : Requester-side request/response bus of the multi-port memory
//               controller; all ports packed side by side.
// Revision    : 1.0
//==============================================================================
`default_nettype none

interface multiport_memory_controller_if #(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
) ();
   logic [NUM_PORTS-1:0]            req_valid;
   logic [NUM_PORTS-1:0]            req_ready;
   logic [NUM_PORTS-1:0]            req_we;
   logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_PORTS-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]           rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

`default_nettype wire

// File: rtl/multiport_memory_controller.sv
//==============================================================================
// Module      : multiport_memory_controller
// Description : Copies BOOT_WORDS ROM words into RAM after reset, then
//               round-robin arbitrates NUM_PORTS requesters onto the RAM.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module multiport_memory_controller #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_PORTS   = 2,
   parameter int DEPTH       = 2**ADDR_WIDTH,
   parameter int BOOT_WORDS  = DEPTH,
   parameter int BYPASS_BOOT = 0,
   parameter logic [DATA_WIDTH-1:0] ROM_BASE = 'hA0,
   localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  boot_done,
   output logic                  memory_error,
   output logic [ADDR_WIDTH-1:0] error_addr,
   output logic [PORT_W-1:0]     error_port,
   multiport_memory_controller_if.slave bus
);

   typedef enum logic [1:0] {
      FETCH_ROM = 2'd0,
      WRITE_RAM = 2'd1,
      RUNNING   = 2'd2,
      ERROR     = 2'd3
   } state_t;

   localparam int     c_MEM_WORDS   = 2**ADDR_WIDTH;
   localparam state_t c_RESET_STATE = (BYPASS_BOOT != 0) ? RUNNING : FETCH_ROM;

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_boot_addr;
   logic [DATA_WIDTH-1:0] r_rom_data;
   logic [PORT_W-1:0]     r_ptr;
   logic [NUM_PORTS-1:0]  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [ADDR_WIDTH-1:0] r_err_addr;
   logic [PORT_W-1:0]     r_err_port;
   logic [DATA_WIDTH-1:0] r_ram [c_MEM_WORDS];

   logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_PORTS];
   logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_PORTS];
   logic [PORT_W-1:0]     w_cand      [NUM_PORTS];
   logic                  w_found, w_xfer, w_addr_ok, w_boot_last;
   logic [PORT_W-1:0]     w_gnt, w_ptr_nxt;
   logic [ADDR_WIDTH-1:0] w_gnt_addr, w_ram_addr;
   logic [DATA_WIDTH-1:0] w_gnt_wdata, w_ram_wdata;
   logic                  w_ram_we, w_ram_re;

   // w_cand[k] is the port examined k-th, starting from the round-robin pointer
   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      assign w_addr_arr[i]  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wdata_arr[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      assign w_cand[i]      = PORT_W'((int'(r_ptr) + i) % NUM_PORTS);
   end

   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!w_found && bus.req_valid[w_cand[k]]) begin
            w_found = 1'b1;
            w_gnt   = w_cand[k];
         end
      end
   end

   assign w_xfer      = (r_state == RUNNING) && w_found;
   assign w_gnt_addr  = w_addr_arr[w_gnt];
   assign w_gnt_wdata = w_wdata_arr[w_gnt];
   assign w_addr_ok   = 32'(w_gnt_addr) < DEPTH;
   assign w_ptr_nxt   = (w_gnt == PORT_W'(NUM_PORTS - 1)) ? '0 : w_gnt + 1'b1;
   assign w_boot_last = (r_boot_addr == ADDR_WIDTH'(BOOT_WORDS - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_ram_we    = 1'b0;
      w_ram_re    = 1'b0;
      w_ram_addr  = w_gnt_addr;
      w_ram_wdata = w_gnt_wdata;
      case (r_state)
         FETCH_ROM: w_state_nxt = WRITE_RAM;
         WRITE_RAM: begin
            w_ram_we    = 1'b1;
            w_ram_addr  = r_boot_addr;
            w_ram_wdata = r_rom_data;
            w_state_nxt = w_boot_last ? RUNNING : FETCH_ROM;
         end
         RUNNING: begin
            if (w_xfer) begin
               if (w_addr_ok) begin
                  w_ram_we = bus.req_we[w_gnt];
                  w_ram_re = !bus.req_we[w_gnt];
               end else begin
                  w_state_nxt = ERROR;
               end
            end
         end
         ERROR:   w_state_nxt = ERROR;
         default: w_state_nxt = ERROR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_RESET_STATE;
         r_boot_addr <= '0;
         r_ptr       <= '0;
         r_rsp_valid <= '0;
         r_err_addr  <= '0;
         r_err_port  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rsp_valid <= w_ram_re ? (NUM_PORTS'(1) << w_gnt) : '0;
         if (r_state == WRITE_RAM && !w_boot_last)
            r_boot_addr <= r_boot_addr + 1'b1;
         if (w_xfer)
            r_ptr <= w_ptr_nxt;
         if (w_xfer && !w_addr_ok) begin
            r_err_addr <= w_gnt_addr;
            r_err_port <= w_gnt;
         end
      end
   end

   // ROM contents are ROM_BASE plus the word index
   always_ff @(posedge clk) begin
      if (w_ram_we)
         r_ram[w_ram_addr] <= w_ram_wdata;
      if (w_ram_re)
         r_rdata <= r_ram[w_ram_addr];
      if (r_state == FETCH_ROM)
         r_rom_data <= ROM_BASE + DATA_WIDTH'(r_boot_addr);
   end

   assign bus.req_ready = w_xfer ? (NUM_PORTS'(1) << w_gnt) : '0;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rdata;
   assign boot_done     = (r_state == RUNNING);
   assign memory_error  = (r_state == ERROR);
   assign error_addr    = r_err_addr;
   assign error_port    = r_err_port;

endmodule

`default_nettype wire

// File: tb/tb_multiport_memory_controller.sv
//==============================================================================
// Module      : tb_multiport_memory_controller
// Description : Directed bench with a behavioural reference model of the
//               boot-loading multi-port memory controller.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_multiport_memory_controller;

   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int NP    = 2;
   localparam int DEPTH = 100;
   localparam int BW    = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          boot_done, memory_error;
   logic [AW-1:0] error_addr;
   logic [0:0]    error_port;

   multiport_memory_controller_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   multiport_memory_controller #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP), .DEPTH(DEPTH),
      .BOOT_WORDS(BW), .BYPASS_BOOT(0), .ROM_BASE(32'hA0)
   ) dut (
      .clk(clk), .rst(rst), .boot_done(boot_done), .memory_error(memory_error),
      .error_addr(error_addr), .error_port(error_port), .bus(bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 booting, 1 running, 2 error
   bit          m_live = 0;
   int          m_mode = 0, m_cyc = 0, m_last = NP - 1;
   bit          m_pend = 0, m_pknown = 0;
   int          m_pport = 0;
   logic [31:0] m_pdata = '0;
   int          m_eaddr = 0, m_eport = 0;
   logic [31:0] m_ram   [256];
   bit          m_known [256];

   initial for (int i = 0; i < 256; i++) m_known[i] = 0;

   always @(negedge clk) begin
      bit          found;
      int          g, a;
      logic [NP-1:0] exp_rdy;
      found = 0;
      g     = 0;
      if (m_mode == 1)
         for (int off = 1; off <= NP; off++)
            if (!found && bus.req_valid[(m_last + off) % NP]) begin
               found = 1;
               g     = (m_last + off) % NP;
            end
      exp_rdy = found ? (NP'(1) << g) : '0;
      a = int'(bus.req_addr[g*AW +: AW]);

      if (m_live) begin
         check("m_boot_done", boot_done, 64'(m_mode == 1));
         check("m_mem_err", memory_error, 64'(m_mode == 2));
         check("m_ready", bus.req_ready, exp_rdy);
         check("m_rsp_valid", bus.rsp_valid, m_pend ? (64'd1 << m_pport) : 64'd0);
         if (m_pend && m_pknown) check("m_rsp_data", bus.rsp_rdata, m_pdata);
         check("m_err_addr", error_addr, 64'(m_eaddr));
         check("m_err_port", error_port, 64'(m_eport));
      end

      if (rst) begin
         m_live = 1; m_mode = 0; m_cyc = 0; m_last = NP - 1;
         m_pend = 0; m_eaddr = 0; m_eport = 0;
      end else if (m_live) begin
         m_pend = 0;
         if (m_mode == 0) begin
            if (m_cyc % 2 == 1) begin
               m_ram[m_cyc/2]   = 32'hA0 + 32'(m_cyc/2);
               m_known[m_cyc/2] = 1;
            end
            m_cyc++;
            if (m_cyc == 2*BW) m_mode = 1;
         end else if (m_mode == 1 && found) begin
            m_last = g;
            if (a >= DEPTH) begin
               m_mode = 2; m_eaddr = a; m_eport = g;
            end else if (bus.req_we[g]) begin
               m_ram[a]   = bus.req_wdata[g*DW +: DW];
               m_known[a] = 1;
            end else begin
               m_pend = 1; m_pport = g; m_pdata = m_ram[a]; m_pknown = m_known[a];
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input bit v, input bit we, input int addr, input logic [31:0] wd);
      bus.req_valid[p]           = v;
      bus.req_we[p]              = we;
      bus.req_addr[p*AW +: AW]   = AW'(addr);
      bus.req_wdata[p*DW +: DW]  = wd;
   endtask

   task automatic wait_boot(input string name);
      int c;
      c = 0;
      while (!boot_done && c < 40) begin
         tick();
         c++;
      end
      check(name, 64'(c), 64'(2*BW));
   endtask

   task automatic rd(input int p, input int addr, input logic [31:0] exp, input string name);
      set_req(p, 1, 0, addr, '0);
      @(negedge clk);
      check({name, "_rdy"}, bus.req_ready, NP'(1) << p);
      tick();
      set_req(p, 0, 0, 0, '0);
      @(negedge clk);
      check({name, "_rsp"}, bus.rsp_valid, NP'(1) << p);
      check({name, "_data"}, bus.rsp_rdata, exp);
      tick();
   endtask

   task automatic wr(input int p, input int addr, input logic [31:0] wd);
      set_req(p, 1, 1, addr, wd);
      @(negedge clk);
      check("wr_rdy", bus.req_ready, NP'(1) << p);
      tick();
      set_req(p, 0, 0, 0, '0);
   endtask

   initial begin
      rst = 1'b1;
      bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
      repeat (2) tick();
      rst = 1'b0;
      wait_boot("boot_len");
      for (int i = 0; i < BW; i++) rd(0, i, 32'hA0 + 32'(i), "boot_rd");
      wr(0, 4, 32'h0000_1234);

      // reset in the middle of boot, with word 2 next
      rst = 1'b1; tick(); rst = 1'b0;
      repeat (4) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      wait_boot("reboot_len");
      rd(0, 4, 32'h0000_1234, "keep4");
      rd(1, 2, 32'h0000_00A2, "reboot_rd2");

      // both ports continuously valid: alternating grants
      wr(0, 16, 32'h1111_0010);
      wr(1, 32, 32'h2222_0020);
      set_req(0, 1, 0, 16, '0);
      set_req(1, 1, 0, 32, '0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k < 4) check("arb_rdy", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
         if (k > 0) begin
            check("arb_rsp", bus.rsp_valid, (k % 2 == 1) ? 2'b01 : 2'b10);
            check("arb_data", bus.rsp_rdata, (k % 2 == 1) ? 32'h1111_0010 : 32'h2222_0020);
         end
         tick();
         if (k == 3) begin
            set_req(0, 0, 0, 0, '0);
            set_req(1, 0, 0, 0, '0);
         end
      end

      // read-after-write on consecutive grants
      set_req(1, 1, 1, 5, 32'hDEAD_BEEF);
      @(negedge clk);
      check("raw_wr_rdy", bus.req_ready, 2'b10);
      tick();
      set_req(1, 0, 0, 0, '0);
      set_req(0, 1, 0, 5, '0);
      @(negedge clk);
      check("raw_rd_rdy", bus.req_ready, 2'b01);
      tick();
      set_req(0, 0, 0, 0, '0);
      @(negedge clk);
      check("raw_rsp", bus.rsp_valid, 2'b01);
      check("raw_data", bus.rsp_rdata, 32'hDEAD_BEEF);
      tick();

      // request held through boot
      rst = 1'b1;
      set_req(0, 1, 0, 2, '0);
      tick();
      rst = 1'b0;
      begin
         int c;
         c = 0;
         while (!boot_done && c < 40) begin
            @(negedge clk);
            check("hold_rdy", bus.req_ready, 2'b00);
            tick();
            c++;
         end
         check("hold_boot_len", 64'(c), 64'(2*BW));
      end
      @(negedge clk);
      check("hold_first_grant", bus.req_ready, 2'b01);
      tick();
      set_req(0, 0, 0, 0, '0);
      @(negedge clk);
      check("hold_data", bus.rsp_rdata, 32'h0000_00A2);
      tick();

      // out-of-range read from port 1; port 0 write must not land
      set_req(1, 1, 0, 100, '0);
      set_req(0, 1, 1, 5, 32'h5555_5555);
      @(negedge clk);
      check("err_accept", bus.req_ready, 2'b10);
      tick();
      set_req(1, 0, 0, 0, '0);
      @(negedge clk);
      check("err_flag", memory_error, 1'b1);
      check("err_addr", error_addr, 8'd100);
      check("err_port", error_port, 1'b1);
      check("err_rdy", bus.req_ready, 2'b00);
      repeat (3) tick();
      set_req(0, 0, 0, 0, '0);
      rst = 1'b1; tick(); rst = 1'b0;
      @(negedge clk);
      check("err_cleared", memory_error, 1'b0);
      wait_boot("err_reboot_len");
      rd(0, 5, 32'hDEAD_BEEF, "err_ram_kept");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/multiport_memory_controller.md
# multiport_memory_controller

Boot-loading, multi-port memory controller: after reset it copies the first BOOT_WORDS words of the internal ROM into the internal RAM, then arbitrates up to NUM_PORTS requesters (fetch, eval, GC) onto the single RAM port with round-robin fairness and a valid/ready handshake. It sits between the CPU-side clients and the ROM/RAM primitives, replacing the single-client controller. Accesses beyond DEPTH put the block into a sticky error state.

## Interface
- ADDR_WIDTH, 16, word address width
- DATA_WIDTH, 32, word width
- NUM_PORTS, 2, number of requesters (1..8)
- DEPTH, 2**ADDR_WIDTH, number of legal RAM words; addresses >= DEPTH are errors
- BOOT_WORDS, DEPTH, words copied ROM->RAM at boot (1..DEPTH)
- BYPASS_BOOT, 0, testbench only: reset goes straight to RUNNING

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- boot_done  out  1  high in RUNNING only
- memory_error  out  1  high in ERROR only
- error_addr  out  ADDR_WIDTH  address of the access that caused ERROR
- error_port  out  $clog2(NUM_PORTS) (min 1)  port that caused ERROR
- req_valid  in  NUM_PORTS  per-port request valid
- req_ready  out  NUM_PORTS  per-port grant, one-hot or zero
- req_we  in  NUM_PORTS  per-port write enable
- req_addr  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_PORTS*DATA_WIDTH  packed write data, same packing
- rsp_valid  out  NUM_PORTS  one-cycle read-data strobe, one-hot or zero
- rsp_rdata  out  DATA_WIDTH  read data, valid when any rsp_valid bit high

## Operation
- States: FETCH_ROM, WRITE_RAM, RUNNING, ERROR; any illegal encoding -> ERROR.
- Reset: state=FETCH_ROM (RUNNING if BYPASS_BOOT), boot_addr=0, rr pointer=0, rsp_valid=0, error_addr=0, error_port=0.
- FETCH_ROM: ROM addressed with boot_addr; -> WRITE_RAM.
- WRITE_RAM: RAM write of rom_data at boot_addr; if boot_addr==BOOT_WORDS-1 -> RUNNING else boot_addr+1, -> FETCH_ROM.
- During boot req_ready=0; requests are held off, never dropped.
- RUNNING arbitration: grant = first i with req_valid[i], searching from rr pointer upward modulo NUM_PORTS. req_ready[grant]=1 combinationally from req_valid; transfer when valid&ready.
- On transfer from port g: pointer <= (g+1) mod NUM_PORTS; no valid -> pointer unchanged.
- Transfer, addr < DEPTH: RAM driven with port g's we/addr/wdata; if read, rsp_valid[g]=1 next cycle with rsp_rdata=RAM data. Writes produce no response.
- Transfer, addr >= DEPTH: no RAM access, no response; error_addr/error_port latched; -> ERROR.
- ERROR: sticky until rst; req_ready=0, RAM write disabled, memory_error=1.
- Read-after-write same address on consecutive grants returns the new data.

## Timing
- Boot: 2*BOOT_WORDS cycles from first clock with rst low; boot_done rises the cycle after the last WRITE_RAM.
- Read latency: 1 cycle, transfer in cycle N -> rsp_valid/rsp_rdata in N+1.
- Throughput: one transfer per cycle, back-to-back across ports.
- req_ready depends combinationally on req_valid and state; no combinational path from rsp to req.
- rst mid-boot or mid-RUNNING: boot restarts from 0 next cycle; an outstanding rsp_valid is cleared, not delivered.
- Error cycle: req_ready asserted in the offending cycle (transfer accepted), memory_error from next cycle.

## Test plan
- Boot, BOOT_WORDS=4, ROM {A0,A1,A2,A3}: boot_done after exactly 8 cycles; reads 0..3 return A0..A3, addr 4 unchanged RAM content.
- Both ports valid continuously after boot, reads of 0x0010 and 0x0020: grants alternate 0,1,0,1; each rsp_valid one cycle after its grant, correct data.
- Port 1 writes 0xDEADBEEF to 0x0005, then port 0 reads 0x0005 next cycle: rsp_valid[0], rsp_rdata=0xDEADBEEF.
- DEPTH=100, port 1 reads addr 100: next cycle memory_error=1, error_addr=100, error_port=1, req_ready=0 thereafter, RAM unchanged; rst clears.
- Request held valid during boot: not granted until boot_done=1, then granted in first RUNNING cycle.
- rst asserted mid-boot at boot_addr=2: boot restarts at 0, boot_done rises 2*BOOT_WORDS cycles after rst release.
